// File: rtl/sine_gen_pkg.sv
// Shared definitions for the UART-tunable sine generator.
//   factor_t  : divide factor carried from the UART loader to clk_divider
//   state_t   : frame parser states of uart_factor_loader
//   *_DEFAULT : default header byte, minimum factor and reset factor
//   frame_chk : checksum of a command frame (XOR of header and payload)
package sine_gen_pkg;

  typedef logic [15:0] factor_t;

  typedef enum logic [1:0] {
    IDLE,
    GET_HI,
    GET_LO,
    GET_CHK
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT     = 8'hA5;
  localparam factor_t    MIN_FACTOR_DEFAULT = 16'd2;
  localparam factor_t    FACTOR_DEFAULT     = 16'd1000;

  function automatic logic [7:0] frame_chk(input logic [7:0] hdr,
                                           input logic [7:0] hi,
                                           input logic [7:0] lo);
    return hdr ^ hi ^ lo;
  endfunction

endpackage

// File: rtl/frame_timeout.sv
// Idle-gap watchdog for the frame parser.
//   clk, rst : clock and synchronous active-high reset
//   clear    : restart the gap count (byte seen, or parser idle)
//   enable   : count this cycle (parser is inside a frame)
//   expired  : combinational pulse on the last allowed idle cycle; the
//              parser abandons the frame on the following edge
module frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // A byte arriving on the final cycle clears the count, so it wins.
  assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_factor_loader.sv
// Parses 4-byte command frames (HEADER, HI, LO, CHK) from the UART receiver
// and holds the divide factor for clk_divider.
//   clk, rst      : clock and synchronous active-high reset
//   rx_data       : received byte, valid while rx_valid is high
//   rx_valid      : one-cycle byte strobe
//   factor        : current divide factor (last accepted value)
//   factor_update : one-cycle pulse, factor was (re)loaded
//   frame_error   : one-cycle pulse, frame rejected (checksum, range, timeout)
//   busy          : parser is inside a frame
//   err_count     : saturating count of rejected frames
module uart_factor_loader
  import sine_gen_pkg::*;
#(
  parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
  parameter factor_t     DEFAULT_FACTOR = FACTOR_DEFAULT,
  parameter factor_t     MIN_FACTOR     = MIN_FACTOR_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output factor_t    factor,
  output logic       factor_update,
  output logic       frame_error,
  output logic       busy,
  output logic [7:0] err_count
);

  state_t     state, state_next;
  logic [7:0] hi_q, lo_q;
  logic       timeout_expired;
  logic       accept, reject;
  factor_t    value;

  assign value = {hi_q, lo_q};

  frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_valid || (state == IDLE)),
    .enable (state != IDLE),
    .expired(timeout_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Bytes inside a frame are always data, even when they
  // equal HEADER: there is no resynchronisation mid-frame.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned
    // (which would infer a latch).
    state_next = state;
    case (state)
      IDLE:    if (rx_valid && (rx_data == HEADER)) state_next = GET_HI;
      GET_HI:  if (rx_valid) state_next = GET_LO;
      GET_LO:  if (rx_valid) state_next = GET_CHK;
      GET_CHK: if (rx_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout_expired) state_next = IDLE;
  end

  // Output / decision logic. A timeout can never coincide with the CHK byte
  // because any rx_valid clears the watchdog, so accept and reject are
  // mutually exclusive.
  always_comb begin
    busy   = (state != IDLE);
    accept = 1'b0;
    reject = 1'b0;
    if ((state == GET_CHK) && rx_valid) begin
      if ((rx_data == frame_chk(HEADER, hi_q, lo_q)) && (value >= MIN_FACTOR)) begin
        accept = 1'b1;
      end else begin
        reject = 1'b1;
      end
    end
    if (timeout_expired) reject = 1'b1;
  end

  // Registered datapath: payload capture, factor, pulses and error count.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q          <= '0;
      lo_q          <= '0;
      factor        <= DEFAULT_FACTOR;
      factor_update <= 1'b0;
      frame_error   <= 1'b0;
      err_count     <= '0;
    end else begin
      factor_update <= accept;
      frame_error   <= reject;
      if ((state == GET_HI) && rx_valid) hi_q <= rx_data;
      if ((state == GET_LO) && rx_valid) lo_q <= rx_data;
      if (accept) factor <= value;
      if (reject && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_factor_loader.sv
// Directed self-checking bench for uart_factor_loader (TIMEOUT_CYCLES=16).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_uart_factor_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] factor;
  logic        factor_update;
  logic        frame_error;
  logic        busy;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int fe0;

  uart_factor_loader #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .factor       (factor),
    .factor_update(factor_update),
    .frame_error  (frame_error),
    .busy         (busy),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the rising edge (pre-update values).
  always @(posedge clk) begin
    if (frame_error) fe_cnt++;
    if (frame_error && factor_update) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one cycle; returns on the falling edge
  // after the capturing rising edge with rx_valid already low.
  task automatic put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_factor", 32'(factor), 32'd1000);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_err",    32'(err_count), 32'd0);
    check("rst_fu",     32'(factor_update), 32'd0);
    check("rst_fe",     32'(frame_error), 32'd0);

    // Good frame, value equal to current factor still pulses update
    fe0 = fe_cnt;
    put(8'hA5);
    check("f1_busy", 32'(busy), 32'd1);
    put(8'h03); put(8'hE8); put(8'h4E);
    check("f1_fu",     32'(factor_update), 32'd1);
    check("f1_factor", 32'(factor), 32'h03E8);
    check("f1_idle",   32'(busy), 32'd0);
    idle(1);
    check("f1_fu_drop", 32'(factor_update), 32'd0);
    idle(1);
    check("f1_no_fe", 32'(fe_cnt), 32'(fe0));

    // Bad checksum, bytes spaced out
    put(8'hA5); idle(2); put(8'h12); idle(2); put(8'h34); idle(2); put(8'h00);
    check("chk_fe",     32'(frame_error), 32'd1);
    check("chk_fu",     32'(factor_update), 32'd0);
    check("chk_err",    32'(err_count), 32'd1);
    check("chk_factor", 32'(factor), 32'h03E8);
    idle(1);
    check("chk_fe_drop", 32'(frame_error), 32'd0);

    // Value below MIN_FACTOR with a valid checksum
    put(8'hA5); put(8'h00); put(8'h01); put(8'hA4);
    check("min_fe",     32'(frame_error), 32'd1);
    check("min_fu",     32'(factor_update), 32'd0);
    check("min_err",    32'(err_count), 32'd2);
    check("min_factor", 32'(factor), 32'h03E8);
    idle(2);

    // Garbage in IDLE is ignored, then minimum legal factor
    fe0 = fe_cnt;
    put(8'h55); idle(1); put(8'h00); put(8'hFF); idle(2);
    check("gb_busy", 32'(busy), 32'd0);
    check("gb_no_fe", 32'(fe_cnt), 32'(fe0));
    check("gb_err", 32'(err_count), 32'd2);
    put(8'hA5); put(8'h00); put(8'h02); put(8'hA7);
    check("two_fu",     32'(factor_update), 32'd1);
    check("two_factor", 32'(factor), 32'd2);

    // Header on the cycle right after CHK starts a new frame
    put(8'hA5);
    check("b2b_busy", 32'(busy), 32'd1);
    put(8'h03); put(8'hE8); put(8'h4E);
    check("b2b_fu",     32'(factor_update), 32'd1);
    check("b2b_factor", 32'(factor), 32'h03E8);
    idle(2);

    // Bytes arriving on the last allowed idle cycle beat the timeout
    put(8'hA5); idle(15); put(8'h00);
    check("edge_busy", 32'(busy), 32'd1);
    check("edge_fe",   32'(frame_error), 32'd0);
    idle(15); put(8'h05); idle(15); put(8'hA0);
    check("edge_fu",     32'(factor_update), 32'd1);
    check("edge_factor", 32'(factor), 32'd5);
    check("edge_err",    32'(err_count), 32'd2);
    idle(2);

    // Timeout after 16 idle cycles
    put(8'hA5); put(8'h03); idle(15);
    check("to_busy_pre", 32'(busy), 32'd1);
    check("to_fe_pre",   32'(frame_error), 32'd0);
    idle(1);
    check("to_fe",     32'(frame_error), 32'd1);
    check("to_busy",   32'(busy), 32'd0);
    check("to_err",    32'(err_count), 32'd3);
    check("to_factor", 32'(factor), 32'd5);
    idle(2);

    // Reset mid-frame: silent discard
    fe0 = fe_cnt;
    put(8'hA5); put(8'h03);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_busy",   32'(busy), 32'd0);
    check("mr_factor", 32'(factor), 32'd1000);
    check("mr_err",    32'(err_count), 32'd0);
    idle(2);
    check("mr_no_fe", 32'(fe_cnt), 32'(fe0));

    // Saturation of err_count
    for (int i = 0; i < 254; i++) begin
      put(8'hA5); put(8'h12); put(8'h34); put(8'h00);
    end
    check("sat_254", 32'(err_count), 32'hFE);
    put(8'hA5); put(8'h12); put(8'h34); put(8'h00);
    check("sat_255", 32'(err_count), 32'hFF);
    put(8'hA5); put(8'h12); put(8'h34); put(8'h00);
    check("sat_fe",  32'(frame_error), 32'd1);
    check("sat_256", 32'(err_count), 32'hFF);
    check("sat_factor", 32'(factor), 32'd1000);
    idle(2);

    check("never_both", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
